// File: rtl/axi_lite_imem_loader.sv
// AXI4-Lite slave that loads instruction memory (strobe + B one cycle after last of AW/W); CTRL gates core_run, STATUS counts loads.
// B and R are held until bready/rready; optional IMEM_LOADER_WSTRB_CHECK_EN rejects imem writes with partial strobes.
module axi_lite_imem_loader #(
   parameter int                    ADDR_WIDTH  = 12,
   parameter int                    IMEM_AW     = 8,
   parameter logic [ADDR_WIDTH-1:0] CTRL_OFFSET = 12'h400
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [31:0]           s_wdata,
   input  logic [3:0]            s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [ADDR_WIDTH-1:0] s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [31:0]           s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   output logic                  instruction_write,
   output logic [31:0]           instruction_data,
   output logic [IMEM_AW-1:0]    instruction_addr,
   output logic                  core_run
);
   typedef enum logic {WS_IDLE, WS_RESP} ws_t;
   typedef enum logic {RS_IDLE, RS_RESP} rs_t;

   localparam int              WA          = ADDR_WIDTH - 2;
   localparam logic [1:0]      RESP_OKAY   = 2'b00;
   localparam logic [1:0]      RESP_SLVERR = 2'b10;
   localparam logic [WA-1:0]   CTRL_W      = CTRL_OFFSET[ADDR_WIDTH-1:2];
   localparam logic [WA-1:0]   STAT_W      = CTRL_W + WA'(1);

   ws_t            r_ws;
   rs_t            r_rs;
   logic           r_aw_held;
   logic           r_w_held;
   logic [WA-1:0]  r_awaddr;
   logic [31:0]    r_wdata;
   logic [3:0]     r_wstrb;
   logic [15:0]    r_count;

   logic           w_aw_hs;
   logic           w_w_hs;
   logic           w_aw_ok;
   logic           w_w_ok;
   logic [WA-1:0]  w_waddr;
   logic [31:0]    w_wdat;
   logic [3:0]     w_wstb;
   logic           w_wr_imem;
   logic           w_wr_ctrl;
   logic           w_strb_ok;
   logic [WA-1:0]  w_raddr;
   logic           w_unused;

   assign s_awready = !r_aw_held && (r_ws == WS_IDLE);
   assign s_wready  = !r_w_held  && (r_ws == WS_IDLE);
   assign s_arready = (r_rs == RS_IDLE);

   assign w_aw_hs   = s_awvalid && s_awready;
   assign w_w_hs    = s_wvalid  && s_wready;
   assign w_aw_ok   = r_aw_held || w_aw_hs;
   assign w_w_ok    = r_w_held  || w_w_hs;

   // Address/data come from the latch if already accepted, else straight off the bus this cycle
   assign w_waddr   = r_aw_held ? r_awaddr : s_awaddr[ADDR_WIDTH-1:2];
   assign w_wdat    = r_w_held  ? r_wdata  : s_wdata;
   assign w_wstb    = r_w_held  ? r_wstrb  : s_wstrb;
   assign w_wr_imem = (w_waddr[WA-1:IMEM_AW] == '0);
   assign w_wr_ctrl = (w_waddr == CTRL_W);
   assign w_raddr   = s_araddr[ADDR_WIDTH-1:2];

`ifdef IMEM_LOADER_WSTRB_CHECK_EN
   assign w_strb_ok = (w_wstb == 4'hF);
   assign w_unused  = ^{s_awaddr[1:0], s_araddr[1:0]};
`else
   assign w_strb_ok = 1'b1;
   assign w_unused  = ^{s_awaddr[1:0], s_araddr[1:0], w_wstb};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ws              <= WS_IDLE;
         r_aw_held         <= 1'b0;
         r_w_held          <= 1'b0;
         r_awaddr          <= '0;
         r_wdata           <= '0;
         r_wstrb           <= '0;
         r_count           <= '0;
         s_bvalid          <= 1'b0;
         s_bresp           <= RESP_OKAY;
         instruction_write <= 1'b0;
         instruction_data  <= '0;
         instruction_addr  <= '0;
         core_run          <= 1'b0;
      end else begin
         instruction_write <= 1'b0;
         case (r_ws)
            WS_IDLE: begin
               if (w_aw_ok && w_w_ok) begin
                  r_ws      <= WS_RESP;
                  s_bvalid  <= 1'b1;
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  if (w_wr_imem) begin
                     if (!core_run && w_strb_ok) begin
                        instruction_write <= 1'b1;
                        instruction_data  <= w_wdat;
                        instruction_addr  <= w_waddr[IMEM_AW-1:0];
                        r_count           <= r_count + 16'd1;
                        s_bresp           <= RESP_OKAY;
                     end else begin
                        s_bresp <= RESP_SLVERR;
                     end
                  end else if (w_wr_ctrl) begin
                     core_run <= w_wdat[0];
                     if (w_wdat[1]) r_count <= '0;
                     s_bresp  <= RESP_OKAY;
                  end else begin
                     s_bresp <= RESP_SLVERR;
                  end
               end else begin
                  if (w_aw_hs) begin
                     r_aw_held <= 1'b1;
                     r_awaddr  <= s_awaddr[ADDR_WIDTH-1:2];
                  end
                  if (w_w_hs) begin
                     r_w_held <= 1'b1;
                     r_wdata  <= s_wdata;
                     r_wstrb  <= s_wstrb;
                  end
               end
            end
            WS_RESP: begin
               if (s_bready) begin
                  s_bvalid <= 1'b0;
                  r_ws     <= WS_IDLE;
               end
            end
            default: r_ws <= WS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rs     <= RS_IDLE;
         s_rvalid <= 1'b0;
         s_rdata  <= '0;
         s_rresp  <= RESP_OKAY;
      end else begin
         case (r_rs)
            RS_IDLE: begin
               if (s_arvalid) begin
                  r_rs     <= RS_RESP;
                  s_rvalid <= 1'b1;
                  if (w_raddr == CTRL_W) begin
                     s_rdata <= {31'b0, core_run};
                     s_rresp <= RESP_OKAY;
                  end else if (w_raddr == STAT_W) begin
                     s_rdata <= {16'b0, r_count};
                     s_rresp <= RESP_OKAY;
                  end else begin
                     s_rdata <= '0;
                     s_rresp <= RESP_SLVERR;
                  end
               end
            end
            RS_RESP: begin
               if (s_rready) begin
                  s_rvalid <= 1'b0;
                  r_rs     <= RS_IDLE;
               end
            end
            default: r_rs <= RS_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_imem_loader.sv
// Directed bench for axi_lite_imem_loader: a small register/memory model predicts each B and R response into queues.
module tb_axi_lite_imem_loader;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] s_awaddr;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [11:0] s_araddr;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;
   logic        instruction_write;
   logic [31:0] instruction_data;
   logic [7:0]  instruction_addr;
   logic        core_run;

   always #5 clk = ~clk;

   axi_lite_imem_loader dut (
      .clk(clk), .reset_n(reset_n),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .instruction_write(instruction_write), .instruction_data(instruction_data),
      .instruction_addr(instruction_addr), .core_run(core_run)
   );

   typedef struct packed {
      logic [1:0]  resp;
      logic        strobe;
      logic [7:0]  addr;
      logic [31:0] data;
   } wexp_t;
   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   wexp_t       wr_q[$];
   rexp_t       rd_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_strobe = 0;
   int          m_strobe = 0;
   logic        m_run    = 1'b0;
   logic [15:0] m_count  = 16'h0;

   always @(negedge clk) if (instruction_write === 1'b1) n_strobe++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic strb_ok(input logic [3:0] strb);
`ifdef IMEM_LOADER_WSTRB_CHECK_EN
      return strb == 4'hF;
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_write(input logic [11:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output wexp_t e);
      e.strobe = 1'b0;
      e.addr   = addr[9:2];
      e.data   = data;
      e.resp   = SLVERR;
      if (addr < 12'h400) begin
         if (!m_run && strb_ok(strb)) begin
            e.strobe = 1'b1;
            e.resp   = OKAY;
            m_count++;
            m_strobe++;
         end
      end else if (addr[11:2] == 10'h100) begin
         m_run = data[0];
         if (data[1]) m_count = '0;
         e.resp = OKAY;
      end
   endtask

   // w_lead > 0: W is accepted w_lead cycles before AW; b_hold: cycles bready stays low
   task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input int b_hold);
      wexp_t e;
      wexp_t got;
      bit    aw_done;
      bit    w_done;
      bit    ok;
      model_write(addr, data, strb, e);
      wr_q.push_back(e);
      s_awaddr = addr;
      s_wdata  = data;
      s_wstrb  = strb;
      s_bready = 1'b0;
      aw_done  = 1'b0;
      w_done   = 1'b0;
      ok       = 1'b0;
      if (w_lead > 0) begin
         s_wvalid = 1'b1;
         for (int c = 0; c < 20 && !w_done; c++) begin
            @(negedge clk);
            w_done = s_wready;
            tick();
         end
         s_wvalid = 1'b0;
         chk("w_first_hs", w_done, 1);
         for (int c = 1; c < w_lead; c++) begin
            chk("early_bvalid", s_bvalid, 0);
            chk("early_strobe", instruction_write, 0);
            tick();
         end
      end
      s_awvalid = 1'b1;
      if (!w_done) s_wvalid = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (s_awvalid && s_awready) aw_done = 1'b1;
         if (s_wvalid && s_wready) w_done = 1'b1;
         tick();
         if (aw_done) s_awvalid = 1'b0;
         if (w_done) s_wvalid = 1'b0;
         ok = aw_done && w_done;
      end
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      chk("aw_w_hs", ok, 1);
      chk("b_latency", s_bvalid, 1);
      for (int c = 0; c < 10 && s_bvalid !== 1'b1; c++) tick();
      got = wr_q.pop_front();
      chk("bresp", s_bresp, got.resp);
      chk("strobe", instruction_write, got.strobe);
      if (got.strobe) begin
         chk("imem_addr", instruction_addr, got.addr);
         chk("imem_data", instruction_data, got.data);
      end
      for (int c = 0; c < b_hold; c++) begin
         tick();
         chk("b_hold_vld", s_bvalid, 1);
         chk("b_hold_resp", s_bresp, got.resp);
         chk("strobe_once", instruction_write, 0);
      end
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      chk("b_done", s_bvalid, 0);
   endtask

   task automatic axi_read(input logic [11:0] addr, input int r_hold);
      rexp_t e;
      bit    ok;
      if (addr[11:2] == 10'h100) begin
         e.data = {31'b0, m_run};
         e.resp = OKAY;
      end else if (addr[11:2] == 10'h101) begin
         e.data = {16'b0, m_count};
         e.resp = OKAY;
      end else begin
         e.data = 32'h0;
         e.resp = SLVERR;
      end
      rd_q.push_back(e);
      s_araddr  = addr;
      s_arvalid = 1'b1;
      s_rready  = 1'b0;
      ok        = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = s_arready;
         tick();
      end
      s_arvalid = 1'b0;
      chk("ar_hs", ok, 1);
      chk("r_latency", s_rvalid, 1);
      e = rd_q.pop_front();
      chk("rdata", s_rdata, e.data);
      chk("rresp", s_rresp, e.resp);
      for (int c = 0; c < r_hold; c++) begin
         tick();
         chk("r_hold_vld", s_rvalid, 1);
         chk("r_hold_data", s_rdata, e.data);
      end
      s_rready = 1'b1;
      tick();
      s_rready = 1'b0;
      chk("r_done", s_rvalid, 0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_bvalid"}, s_bvalid, 0);
      chk({tag, "_rvalid"}, s_rvalid, 0);
      chk({tag, "_bresp"}, s_bresp, 0);
      chk({tag, "_rdata"}, s_rdata, 0);
      chk({tag, "_strobe"}, instruction_write, 0);
      chk({tag, "_iaddr"}, instruction_addr, 0);
      chk({tag, "_idata"}, instruction_data, 0);
      chk({tag, "_core_run"}, core_run, 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      s_awaddr  = '0; s_awvalid = 1'b0;
      s_wdata   = '0; s_wstrb   = 4'hF; s_wvalid = 1'b0;
      s_bready  = 1'b0;
      s_araddr  = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      repeat (3) tick();
      chk_outputs_zero("rst");
      reset_n = 1'b1;
      tick();

      // Test 1: AW and W in the same cycle
      axi_write(12'h010, 32'h00500093, 4'hF, 0, 0);
      chk("t1_addr_held", instruction_addr, 8'h04);
      chk("t1_data_held", instruction_data, 32'h00500093);

      // Test 2: W three cycles ahead of AW, B back-pressured
      axi_write(12'h3FC, 32'hDEADBEEF, 4'hF, 3, 5);
      chk("t2_addr", instruction_addr, 8'hFF);

      // Test 3: loads refused while the core runs
      axi_write(12'h400, 32'h1, 4'hF, 0, 0);
      chk("t3_core_run", core_run, 1);
      axi_write(12'h000, 32'h12345678, 4'hF, 0, 1);
      chk("t3_addr_kept", instruction_addr, 8'hFF);
      axi_read(12'h400, 0);

      // Test 4: STATUS counting and clear
      axi_write(12'h400, 32'h2, 4'hF, 0, 0);
      chk("t4_core_run_off", core_run, 0);
      axi_read(12'h404, 0);
      for (int i = 0; i < 3; i++) axi_write(12'h100 + 12'(i * 4), 32'hA0000000 + i, 4'hF, i, 0);
      axi_read(12'h404, 2);
      axi_write(12'h400, 32'h2, 4'hF, 0, 0);
      axi_read(12'h404, 0);
      chk("t4_core_run_same", core_run, 0);
      axi_write(12'h400, 32'h3, 4'hF, 0, 0);
      axi_read(12'h400, 0);
      axi_read(12'h404, 0);
      axi_write(12'h400, 32'h0, 4'hF, 0, 0);
      axi_write(12'h020, 32'hCAFE0001, 4'h3, 0, 0);
      axi_write(12'h404, 32'hFFFF, 4'hF, 0, 0);

      // Test 5: unmapped and imem-window reads, unmapped write
      axi_read(12'h020, 0);
      axi_write(12'h7F0, 32'h1, 4'hF, 0, 0);
      chk("t5_core_run", core_run, 0);
      axi_read(12'h404, 0);

      // Test 6: reset with R and B pending and a new AW presented
      axi_write(12'h400, 32'h1, 4'hF, 0, 0);
      s_araddr = 12'h404; s_arvalid = 1'b1; s_rready = 1'b0;
      tick();
      s_arvalid = 1'b0;
      s_awaddr = 12'h400; s_wdata = 32'h3; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
      tick();
      s_wvalid = 1'b0;
      s_awaddr = 12'h040; s_wdata = 32'h77;
      chk("t6_b_pend", s_bvalid, 1);
      chk("t6_r_pend", s_rvalid, 1);
      tick();
      #2 reset_n = 1'b0;
      #1;
      chk_outputs_zero("t6_rst");
      m_run = 1'b0; m_count = '0;
      s_awvalid = 1'b0;
      tick();
      tick();
      chk_outputs_zero("t6_rst_hold");
      reset_n = 1'b1;
      tick();

      // Held W must not survive a reset
      s_wdata = 32'h55; s_wvalid = 1'b1;
      tick();
      s_wvalid = 1'b0;
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      tick();
      s_awaddr = 12'h050; s_awvalid = 1'b1;
      tick();
      s_awvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("t6_no_stale_b", s_bvalid, 0);
         chk("t6_no_stale_strobe", instruction_write, 0);
         tick();
      end
      s_wdata = 32'h0ABC0001; s_wvalid = 1'b1;
      m_count++; m_strobe++;
      tick();
      s_wvalid = 1'b0;
      chk("t6_late_w_b", s_bvalid, 1);
      chk("t6_late_w_resp", s_bresp, OKAY);
      chk("t6_late_w_strobe", instruction_write, 1);
      chk("t6_late_w_addr", instruction_addr, 8'h14);
      chk("t6_late_w_data", instruction_data, 32'h0ABC0001);
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;

      axi_write(12'h010, 32'h00500093, 4'hF, 0, 0);
      chk("t6_t1_addr", instruction_addr, 8'h04);
      axi_read(12'h404, 0);

      repeat (2) tick();
      chk("strobe_total", n_strobe, m_strobe);
      chk("wr_q_empty", wr_q.size(), 0);
      chk("rd_q_empty", rd_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
